// File: rtl/tik_chain_counter.sv
// tik_chain_counter
// -----------------------------------------------------------------------------
// Cascade of N modulo counters advanced by a common tick. Stage 0 is the least
// significant. Supports up/down counting with a combinational carry/borrow
// ripple, parallel load with per-field saturation, synchronous clear to
// INIT_VAL, per-stage editing (no carry) while stopped, and terminal-count
// detection.
//
// Ports
//   clk       clock
//   rst       asynchronous active-high reset (o_time <= INIT_VAL)
//   clr       synchronous load of INIT_VAL
//   load      synchronous load of load_val (fields saturate to STAGE_MAX-1)
//   load_val  packed load value, SW bits per stage
//   run       enables tick counting; when low, up/dn edit the selected stage
//   mode_dn   0 = count up, 1 = count down
//   i_tik     one-cycle count-enable pulse
//   sel       stage targeted by up/dn edits (values >= N are ignored)
//   up, dn    edit pulses (both together = no change)
//   o_time    registered stage values, SW bits per stage
//   o_tik     registered carry/borrow out of stage N-1 (one-cycle pulse)
//   o_zero    combinational: all stages are zero
//   o_done    registered pulse when a down-count reaches all-zero
// -----------------------------------------------------------------------------
module tik_chain_counter #(
  parameter int              N            = 4,
  parameter int              SW           = 7,
  parameter logic [8*N-1:0]  STAGE_MAX    = {8'd24, 8'd60, 8'd60, 8'd100},
  parameter logic [SW*N-1:0] INIT_VAL     = '0,
  parameter bit              STOP_AT_ZERO = 1'b1,
  parameter int              SELW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [N*SW-1:0]   load_val,
  input  logic              run,
  input  logic              mode_dn,
  input  logic              i_tik,
  input  logic [SELW-1:0]   sel,
  input  logic              up,
  input  logic              dn,
  output logic [N*SW-1:0]   o_time,
  output logic              o_tik,
  output logic              o_zero,
  output logic              o_done
);

  logic [N*SW-1:0] time_reg, time_next;
  logic            tik_reg, tik_next;
  logic            done_reg, done_next;

  // Candidate next values for each kind of update, assembled per stage.
  logic [N*SW-1:0] up_val;     // value after one up tick
  logic [N*SW-1:0] dn_val;     // value after one down tick
  logic [N*SW-1:0] edit_val;   // value after an edit of the selected stage
  logic [N*SW-1:0] load_sat;   // load_val with out-of-range fields clamped

  // Ripple chains: cy_up[k] / bw_dn[k] = stage k receives a carry / borrow.
  // Stage 0 always receives one on a tick, so the final bit is the chain output.
  logic [N:0] cy_up;
  logic [N:0] bw_dn;

  assign cy_up[0] = 1'b1;
  assign bw_dn[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_stage
      localparam int          MAX_I  = int'(STAGE_MAX[8*gi +: 8]);
      // Terminal value compared in stage width (truncated to SW bits).
      localparam logic [SW-1:0] MAX_M1 = SW'(MAX_I - 1);

      logic [SW-1:0] cur;
      logic [SW-1:0] ld_fld;
      logic [SW-1:0] inc_wrap;
      logic [SW-1:0] dec_wrap;
      logic          at_max;
      logic          is_zero;
      logic          sel_hit;

      assign cur      = time_reg[SW*gi +: SW];
      assign ld_fld   = load_val[SW*gi +: SW];
      assign at_max   = (cur == MAX_M1);
      assign is_zero  = (cur == '0);
      assign inc_wrap = at_max  ? '0     : cur + 1'b1;
      assign dec_wrap = is_zero ? MAX_M1 : cur - 1'b1;
      assign sel_hit  = (int'(sel) == gi);

      assign cy_up[gi+1] = cy_up[gi] & at_max;
      assign bw_dn[gi+1] = bw_dn[gi] & is_zero;

      assign up_val[SW*gi +: SW] = cy_up[gi] ? inc_wrap : cur;
      assign dn_val[SW*gi +: SW] = bw_dn[gi] ? dec_wrap : cur;

      // Only a lone up or lone dn edits; sel outside 0..N-1 hits no stage.
      assign edit_val[SW*gi +: SW] = (sel_hit && (up ^ dn)) ? (up ? inc_wrap : dec_wrap) : cur;

      assign load_sat[SW*gi +: SW] = (int'(ld_fld) >= MAX_I) ? MAX_M1 : ld_fld;
    end
  endgenerate

  always_comb begin
    time_next = time_reg;
    tik_next  = 1'b0;
    done_next = 1'b0;
    if (clr) begin
      time_next = INIT_VAL;
    end else if (load) begin
      time_next = load_sat;
    end else if (run) begin
      if (i_tik) begin
        if (!mode_dn) begin
          time_next = up_val;
          tik_next  = cy_up[N];
        end else if (bw_dn[N]) begin
          // Borrow ripples all the way out only when every stage is zero.
          if (!STOP_AT_ZERO) begin
            time_next = dn_val;
            tik_next  = 1'b1;
          end
        end else begin
          time_next = dn_val;
          done_next = (dn_val == '0);
        end
      end
    end else begin
      time_next = edit_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_reg <= INIT_VAL;
      tik_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      time_reg <= time_next;
      tik_reg  <= tik_next;
      done_reg <= done_next;
    end
  end

  assign o_time = time_reg;
  assign o_tik  = tik_reg;
  assign o_done = done_reg;
  assign o_zero = (time_reg == '0);

endmodule

// File: tb/tb_tik_chain_counter.sv
// Testbench for tik_chain_counter. Two instances share all inputs: dut_a holds
// at zero in down mode and clears to 5, dut_b wraps in down mode and clears to
// 0. The reference model treats the whole chain as one mixed-radix integer.
module tb_tik_chain_counter;

  localparam int N    = 4;
  localparam int SW   = 7;
  localparam int SELW = 3;
  localparam int MODS [4] = '{100, 60, 60, 24};
  localparam int WTS  [4] = '{1, 100, 6000, 360000};
  localparam int PROD = 8640000;
  localparam int INIT_A = 5;
  localparam int INIT_B = 0;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic            load = 1'b0;
  logic [N*SW-1:0] load_val = '0;
  logic            run = 1'b0;
  logic            mode_dn = 1'b0;
  logic            i_tik = 1'b0;
  logic [SELW-1:0] sel = '0;
  logic            up = 1'b0;
  logic            dn = 1'b0;

  logic [N*SW-1:0] a_time, b_time;
  logic            a_tik, a_zero, a_done;
  logic            b_tik, b_zero, b_done;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  tik_chain_counter #(
    .N(N), .SW(SW), .INIT_VAL(28'd5), .STOP_AT_ZERO(1'b1), .SELW(SELW)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .run(run), .mode_dn(mode_dn), .i_tik(i_tik), .sel(sel), .up(up), .dn(dn),
    .o_time(a_time), .o_tik(a_tik), .o_zero(a_zero), .o_done(a_done)
  );

  tik_chain_counter #(
    .N(N), .SW(SW), .INIT_VAL(28'd0), .STOP_AT_ZERO(1'b0), .SELW(SELW)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
    .run(run), .mode_dn(mode_dn), .i_tik(i_tik), .sel(sel), .up(up), .dn(dn),
    .o_time(b_time), .o_tik(b_tik), .o_zero(b_zero), .o_done(b_done)
  );

  // ---------------- helpers ----------------
  function automatic logic [27:0] pk(input int s3, input int s2, input int s1, input int s0);
    return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endfunction

  function automatic logic [27:0] tot2vec(input int t);
    logic [27:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[7*k +: 7] = 7'((t / WTS[k]) % MODS[k]);
    return v;
  endfunction

  function automatic int vec2tot_sat(input logic [27:0] v);
    int t;
    int f;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      f = int'(v[7*k +: 7]);
      if (f >= MODS[k]) f = MODS[k] - 1;
      t += f * WTS[k];
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int tot;
    bit tik;
    bit done;
  } mstate_t;

  mstate_t ma, mb;

  function automatic mstate_t model_step(input mstate_t s, input bit stop, input int init_tot);
    mstate_t r;
    int d, nd, k;
    r.tot  = s.tot;
    r.tik  = 1'b0;
    r.done = 1'b0;
    if (clr) begin
      r.tot = init_tot;
    end else if (load) begin
      r.tot = vec2tot_sat(load_val);
    end else if (run) begin
      if (i_tik) begin
        if (!mode_dn) begin
          if (s.tot == PROD - 1) begin r.tot = 0; r.tik = 1'b1; end
          else r.tot = s.tot + 1;
        end else if (s.tot == 0) begin
          if (!stop) begin r.tot = PROD - 1; r.tik = 1'b1; end
        end else begin
          r.tot  = s.tot - 1;
          r.done = (r.tot == 0);
        end
      end
    end else if ((up != dn) && (int'(sel) < N)) begin
      k  = int'(sel);
      d  = (s.tot / WTS[k]) % MODS[k];
      nd = up ? (d + 1) % MODS[k] : (d + MODS[k] - 1) % MODS[k];
      r.tot = s.tot + (nd - d) * WTS[k];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= '{tot: INIT_A, tik: 1'b0, done: 1'b0};
      mb <= '{tot: INIT_B, tik: 1'b0, done: 1'b0};
    end else begin
      ma <= model_step(ma, 1'b1, INIT_A);
      mb <= model_step(mb, 1'b0, INIT_B);
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("a_time", 32'(a_time), 32'(tot2vec(ma.tot)));
      chk("a_tik",  32'(a_tik),  32'(ma.tik));
      chk("a_done", 32'(a_done), 32'(ma.done));
      chk("a_zero", 32'(a_zero), 32'(ma.tot == 0));
      chk("b_time", 32'(b_time), 32'(tot2vec(mb.tot)));
      chk("b_tik",  32'(b_tik),  32'(mb.tik));
      chk("b_done", 32'(b_done), 32'(mb.done));
      chk("b_zero", 32'(b_zero), 32'(mb.tot == 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; load = 1'b0; run = 1'b0; i_tik = 1'b0; up = 1'b0; dn = 1'b0;
  endtask

  int done_cnt, tik_cnt;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    checking = 1'b1;
    #1;
    $display("reset state");
    chk("rst_a_time", 32'(a_time), 32'd5);
    chk("rst_a_tik",  32'(a_tik), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_zero", 32'(a_zero), 32'd0);
    chk("rst_b_zero", 32'(b_zero), 32'd1);
    step(); step();
    rst = 1'b0;
    step();

    // 1: up-mode wrap of the full chain
    $display("test1 up wrap");
    load = 1'b1; load_val = pk(23, 59, 59, 99);
    step();
    load = 1'b0; run = 1'b1; i_tik = 1'b1; mode_dn = 1'b0;
    step();
    chk("t1_time", 32'(a_time), 32'd0);
    chk("t1_tik",  32'(a_tik), 32'd1);
    i_tik = 1'b0;
    step();
    chk("t1_tik_clear", 32'(a_tik), 32'd0);

    // 2/3: down mode from {0,0,1,0}, 100 ticks then 5 more
    $display("test2/3 down count");
    idle(); load = 1'b1; load_val = pk(0, 0, 1, 0);
    step();
    load = 1'b0; run = 1'b1; mode_dn = 1'b1; i_tik = 1'b1;
    done_cnt = 0; tik_cnt = 0;
    for (int i = 1; i <= 105; i++) begin
      step();
      if (a_done === 1'b1) done_cnt++;
      if (a_tik === 1'b1) tik_cnt++;
      if (i == 100) begin
        chk("t2_time", 32'(a_time), 32'd0);
        chk("t2_zero", 32'(a_zero), 32'd1);
        chk("t2_done", 32'(a_done), 32'd1);
        chk("t2_b_done", 32'(b_done), 32'd1);
      end
      if (i == 101) begin
        chk("t3_b_time", 32'(b_time), 32'(pk(23, 59, 59, 99)));
        chk("t3_b_tik",  32'(b_tik), 32'd1);
      end
    end
    chk("t2_hold_time", 32'(a_time), 32'd0);
    chk("t2_done_count", 32'(done_cnt), 32'd1);
    chk("t2_tik_count", 32'(tik_cnt), 32'd0);

    // 4: edits with run=0
    $display("test4 edits");
    idle(); mode_dn = 1'b0;
    load = 1'b1; load_val = pk(3, 7, 59, 10);
    step();
    load = 1'b0; sel = 3'd1; up = 1'b1;
    step();
    chk("t4_up_wrap", 32'(a_time), 32'(pk(3, 7, 0, 10)));
    up = 1'b0; load = 1'b1; load_val = pk(3, 7, 0, 0);
    step();
    load = 1'b0; sel = 3'd0; dn = 1'b1;
    step();
    chk("t4_dn_wrap", 32'(a_time), 32'(pk(3, 7, 0, 99)));
    up = 1'b1; dn = 1'b1; i_tik = 1'b1;
    step();
    chk("t4_up_dn", 32'(a_time), 32'(pk(3, 7, 0, 99)));
    dn = 1'b0; sel = 3'd5;
    step();
    chk("t4_sel_oob", 32'(a_time), 32'(pk(3, 7, 0, 99)));

    // 5: priority and saturation
    $display("test5 priority");
    idle(); clr = 1'b1; load = 1'b1; run = 1'b1; i_tik = 1'b1; load_val = pk(1, 2, 3, 4);
    step();
    chk("t5_clr_a", 32'(a_time), 32'd5);
    chk("t5_clr_b", 32'(b_time), 32'd0);
    clr = 1'b0; load_val = pk(0, 0, 0, 120);
    step();
    chk("t5_sat", 32'(a_time), 32'd99);

    // 6: asynchronous reset between edges
    $display("test6 async reset");
    idle(); load = 1'b1; load_val = pk(0, 0, 0, 1);
    step();
    load = 1'b0; run = 1'b1; i_tik = 1'b1; mode_dn = 1'b1;
    step();
    chk("t6_done_pre", 32'(a_done), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_time", 32'(a_time), 32'd5);
    chk("t6_tik",  32'(a_tik), 32'd0);
    chk("t6_done", 32'(a_done), 32'd0);
    step();
    rst = 1'b0; mode_dn = 1'b0;
    step();
    chk("t6_resume", 32'(a_time), 32'd6);

    // Randomized phase
    $display("random phase");
    for (int i = 0; i < 3000; i++) begin
      idle();
      rst     = ($urandom_range(0, 299) == 0);
      clr     = ($urandom_range(0, 63) == 0);
      load    = ($urandom_range(0, 15) == 0);
      run     = ($urandom_range(0, 3) != 0);
      i_tik   = ($urandom_range(0, 9) < 7);
      up      = ($urandom_range(0, 3) == 0);
      dn      = ($urandom_range(0, 3) == 0);
      sel     = SELW'($urandom_range(0, 7));
      if ($urandom_range(0, 31) == 0) mode_dn = ~mode_dn;
      case ($urandom_range(0, 3))
        0:       load_val = pk($urandom_range(0, 127), $urandom_range(0, 127),
                               $urandom_range(0, 127), $urandom_range(0, 127));
        1:       load_val = pk(0, 0, 0, $urandom_range(0, 5));
        2:       load_val = pk(23, 59, 59, $urandom_range(95, 99));
        default: load_val = pk(0, 0, $urandom_range(0, 1), $urandom_range(0, 3));
      endcase
      step();
    end
    idle(); rst = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
